// File: rtl/srt_divider_param.sv
// Iterative radix-2 non-restoring divider, signed/unsigned, WIDTH-bit operands.
// Latency: done WIDTH+4 cycles after start accept; 2 cycles for divide-by-zero or MIN/-1.
// No backpressure: start is ignored while busy (including the done cycle).
module srt_divider_param #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    ITER     = 3'd2,
    CORRECT  = 3'd3,
    SIGN_FIX = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;        // captured dividend
  logic [WIDTH-1:0] b_r;        // captured divisor
  logic             neg_a_r;    // dividend is negative (signed mode only)
  logic             neg_b_r;    // divisor is negative (signed mode only)
  logic             dz_r;       // divisor was zero
  logic             ov_r;       // signed MIN / -1
  logic [WIDTH:0]   p_r;        // partial remainder, one extra bit for the sign
  logic [WIDTH-1:0] q_r;        // dividend shifts out, quotient shifts in
  logic [WIDTH:0]   d_r;        // divisor magnitude, zero-extended
  logic [CNT_W-1:0] cnt_r;

  logic             signed_in;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_next;

  assign signed_in = SIGNED_EN && signed_mode;

  // One non-restoring step: shift {P,Q} left, then subtract or add the divisor by P's sign.
  always_comb begin
    p_shift = {p_r[WIDTH-1:0], q_r[WIDTH-1]};
    p_next  = p_shift;
    if (p_r[WIDTH]) begin
      p_next = p_shift + d_r;
    end else begin
      p_next = p_shift - d_r;
    end
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      neg_a_r     <= 1'b0;
      neg_b_r     <= 1'b0;
      dz_r        <= 1'b0;
      ov_r        <= 1'b0;
      p_r         <= '0;
      q_r         <= '0;
      d_r         <= '0;
      cnt_r       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (busy) begin
            // This is the done cycle: busy drops now, start is not looked at.
            busy <= 1'b0;
          end else if (start) begin
            a_r     <= dividend;
            b_r     <= divisor;
            neg_a_r <= signed_in && dividend[WIDTH-1];
            neg_b_r <= signed_in && divisor[WIDTH-1];
            dz_r    <= (divisor == '0);
            ov_r    <= signed_in && (dividend == MIN_VAL) && (divisor == ALL_ONES);
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end

        LOAD: begin
          p_r   <= '0;
          cnt_r <= '0;
          // Magnitudes: MIN negates to itself, which is its correct unsigned magnitude.
          q_r   <= neg_a_r ? -a_r : a_r;
          d_r   <= {1'b0, (neg_b_r ? -b_r : b_r)};
          if (dz_r || ov_r) begin
            state <= DONE;
          end else begin
            state <= ITER;
          end
        end

        ITER: begin
          p_r   <= p_next;
          q_r   <= {q_r[WIDTH-2:0], ~p_next[WIDTH]};
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state <= CORRECT;
          end
        end

        CORRECT: begin
          // A negative final partial remainder is one divisor short.
          if (p_r[WIDTH]) begin
            p_r <= p_r + d_r;
          end
          state <= SIGN_FIX;
        end

        SIGN_FIX: begin
          // Truncation toward zero: remainder takes the dividend's sign.
          if (neg_a_r ^ neg_b_r) begin
            q_r <= -q_r;
          end
          if (neg_a_r) begin
            p_r <= {1'b0, -p_r[WIDTH-1:0]};
          end
          state <= DONE;
        end

        DONE: begin
          done        <= 1'b1;
          div_by_zero <= dz_r;
          overflow    <= ov_r;
          if (dz_r) begin
            quotient  <= ALL_ONES;
            remainder <= a_r;
          end else if (ov_r) begin
            quotient  <= MIN_VAL;
            remainder <= '0;
          end else begin
            quotient  <= q_r;
            remainder <= p_r[WIDTH-1:0];
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srt_divider_param.sv
// Randomized and directed bench for srt_divider_param against an arithmetic reference model.
// Latency: checks done arrives WIDTH+4 cycles after accept (2 for special cases).
// Backpressure: checks start is ignored mid-operation and in the done cycle.
module tb_srt_divider_param;

  localparam int W = 8;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  int checks;
  int errors;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  srt_divider_param #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, C-style truncation toward zero.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output bit dz, output bit ov);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    dz = 1'b0;
    ov = 1'b0;
    if (b == '0) begin
      dz = 1'b1;
      q  = '1;
      r  = a;
    end else if (sm && a == MINV && b == '1) begin
      ov = 1'b1;
      q  = MINV;
      r  = '0;
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      if (sm && a[W-1]) sa = sa - (longint'(1) << W);
      if (sm && b[W-1]) sb = sb - (longint'(1) << W);
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
    end
  endfunction

  // Issue one division and check result, flags, latency and busy/done framing.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                        input int glitch_at, input bit poke_done, input string tag);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    bit edz;
    bit eov;
    int lat;
    int g;
    model(a, b, sm, eq, er, edz, eov);
    g = 0;
    while (busy && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    dividend    = a;
    divisor     = b;
    signed_mode = sm;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_accept"}, busy, 1);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n == glitch_at) begin
        start       = 1'b1;
        dividend    = W'($urandom);
        divisor     = W'($urandom);
        signed_mode = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, (edz || eov) ? 2 : W + 4);
    check({tag, "_quot"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_dz"}, div_by_zero, edz);
    check({tag, "_ov"}, overflow, eov);
    check({tag, "_busy_done"}, busy, 1);
    last_q = eq;
    last_r = er;
    if (poke_done) begin
      start    = 1'b1;
      dividend = 8'd9;
      divisor  = 8'd3;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_post_done"}, {busy, done}, 2'b00);
  endtask

  logic [W-1:0] ra;
  logic [W-1:0] rb;
  bit rs;
  int sel;

  initial begin
    checks      = 0;
    errors      = 0;
    last_q      = '0;
    last_r      = '0;
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    #3;
    check("reset_outputs", {quotient, remainder, busy, done, div_by_zero, overflow}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'd200, 8'd10, 1'b0, 0, 1'b0, "u200_10");
    run_op(8'hC7, 8'h05, 1'b1, 0, 1'b0, "s_m57_5");
    run_op(8'd57, 8'hFB, 1'b1, 0, 1'b0, "s_57_m5");
    run_op(8'd255, 8'd1, 1'b0, 0, 1'b0, "u255_1");
    run_op(8'd255, 8'd255, 1'b0, 0, 1'b0, "u255_255");
    run_op(8'd7, 8'd200, 1'b0, 0, 1'b0, "u7_200");
    run_op(8'd100, 8'd0, 1'b0, 0, 1'b0, "u100_0");
    run_op(8'd57, 8'd5, 1'b0, 0, 1'b0, "u57_5");
    run_op(8'h80, 8'hFF, 1'b1, 0, 1'b0, "s_min_m1");
    run_op(8'h80, 8'hFF, 1'b0, 0, 1'b0, "u128_255");
    run_op(8'hC7, 8'h00, 1'b1, 0, 1'b1, "s_dz_poke");
    run_op(8'd123, 8'd7, 1'b0, 3, 1'b1, "glitch_c3");

    // Outputs hold between completions.
    repeat (5) @(posedge clk);
    #1;
    check("hold_quot", quotient, last_q);
    check("hold_rem", remainder, last_r);

    // Reset in the middle of an operation aborts it silently.
    dividend    = 8'd200;
    divisor     = 8'd10;
    signed_mode = 1'b0;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n < 5; n++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_outputs", {quotient, remainder, busy, done, div_by_zero, overflow}, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_done", done, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(8'hC7, 8'h05, 1'b1, 0, 1'b0, "after_rst");

    for (int i = 0; i < 60; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rs  = 1'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = '0;
      if (sel == 1) begin
        ra = MINV;
        rb = '1;
      end
      if (sel == 2) rb = W'($urandom_range(1, 3));
      run_op(ra, rb, rs, (sel == 3) ? 3 : 0, (sel == 4), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
